// File: rtl/step_sched_pkg.sv
// Shared types and constants for the step scheduler and its shadow FSM model.
package step_sched_pkg;

  // Controller states of the scheduler
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } ctrl_state_t;

  // Encodings of the shared 5-state step-counting FSM
  localparam logic [2:0] S0 = 3'b000;
  localparam logic [2:0] S1 = 3'b001;
  localparam logic [2:0] S2 = 3'b010;
  localparam logic [2:0] S3 = 3'b011;
  localparam logic [2:0] S4 = 3'b100;

  // Output O of the FSM while it sits in its reset state
  localparam logic MODEL_O_RST = 1'b1;

endpackage

// File: rtl/step_fsm_model.sv
// Cycle-exact shadow of the shared step-counting FSM, advanced by each step pulse.
module step_fsm_model (
  input  logic       clk,
  input  logic       rst,
  input  logic       step,
  output logic [2:0] model_state,
  output logic       model_o
);
  import step_sched_pkg::*;

  logic [2:0] r_state;
  logic       r_o;

  // Advance the predicted state/output on every edge where a step is presented
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S0;
      r_o     <= MODEL_O_RST;
    end else if (step) begin
      case (r_state)
        S0: begin
          r_state <= S1;
          r_o     <= 1'b0;
        end
        S1: r_state <= S2;
        S2: begin
          r_state <= S3;
          r_o     <= 1'b1;
        end
        S3: begin
          r_state <= S4;
          r_o     <= 1'b0;
        end
        S4: r_state <= S1;
        default: begin
          r_state <= S0;
          r_o     <= MODEL_O_RST;
        end
      endcase
    end
  end

  assign model_state = r_state;
  assign model_o     = r_o;

endmodule

// File: rtl/step_sched_ctrl.sv
// Round-robin two-requester scheduler that drives step pulses into the shared FSM.
module step_sched_ctrl #(
  parameter int CNT_W = 4,
  parameter int GAP_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req,
  input  logic [CNT_W-1:0] cnt0,
  input  logic [CNT_W-1:0] cnt1,
  input  logic [GAP_W-1:0] gap,
  output logic [1:0]       grant,
  output logic [1:0]       done,
  output logic             busy,
  output logic             step_o,
  output logic [2:0]       model_state,
  output logic             model_o
);
  import step_sched_pkg::*;

  ctrl_state_t      r_state;
  ctrl_state_t      w_next;
  logic [CNT_W-1:0] r_remaining;
  logic [GAP_W-1:0] r_gapReg;
  logic [GAP_W-1:0] r_gapCnt;
  logic [1:0]       r_grant;
  logic [1:0]       r_done;
  logic             r_step;
  logic             r_lastServed;
  logic             w_winner;
  logic [1:0]       w_winOh;
  logic [CNT_W-1:0] w_winCnt;
  logic [CNT_W-1:0] w_remDec;

  // Arbitration and next-state decision; a tie goes to whoever was not served last
  always_comb begin
    w_next   = r_state;
    w_winner = (req == 2'b10) || ((req == 2'b11) && !r_lastServed);
    w_winOh  = w_winner ? 2'b10 : 2'b01;
    w_winCnt = w_winner ? cnt1 : cnt0;
    w_remDec = r_remaining - CNT_W'(1);
    case (r_state)
      IDLE: begin
        if (req != 2'b00) begin
          w_next = (w_winCnt != '0) ? PULSE : DONE;
        end
      end
      PULSE: begin
        if (w_remDec == '0) begin
          w_next = DONE;
        end else if (r_gapReg == '0) begin
          w_next = PULSE;
        end else begin
          w_next = GAP;
        end
      end
      GAP: begin
        if (r_gapCnt <= GAP_W'(1)) begin
          w_next = PULSE;
        end
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Registered controller state, grant/done/step outputs and service bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_remaining  <= '0;
      r_gapReg     <= '0;
      r_gapCnt     <= '0;
      r_grant      <= 2'b00;
      r_done       <= 2'b00;
      r_step       <= 1'b0;
      r_lastServed <= 1'b1;
    end else begin
      r_state <= w_next;
      r_step  <= (w_next == PULSE);
      r_done  <= 2'b00;
      case (r_state)
        IDLE: begin
          if (req != 2'b00) begin
            r_grant     <= w_winOh;
            r_remaining <= w_winCnt;
            r_gapReg    <= gap;
            if (w_next == DONE) begin
              r_done <= w_winOh;
            end
          end
        end
        PULSE: begin
          r_remaining <= w_remDec;
          if (w_next == GAP) begin
            r_gapCnt <= r_gapReg;
          end
          if (w_next == DONE) begin
            r_done <= r_grant;
          end
        end
        GAP: begin
          r_gapCnt <= r_gapCnt - GAP_W'(1);
        end
        DONE: begin
          r_grant      <= 2'b00;
          r_lastServed <= r_grant[1];
        end
        default: r_grant <= 2'b00;
      endcase
    end
  end

  assign grant  = r_grant;
  assign done   = r_done;
  assign busy   = |r_grant;
  assign step_o = r_step;

  step_fsm_model u_model (
    .clk         (clk),
    .rst         (rst),
    .step        (r_step),
    .model_state (model_state),
    .model_o     (model_o)
  );

endmodule

// File: tb/tb_step_sched_ctrl.sv
// Directed, table-driven bench for the step scheduler with hand-computed expectations.
module tb_step_sched_ctrl;

  logic       clk;
  logic       rst;
  logic [1:0] req;
  logic [3:0] cnt0;
  logic [3:0] cnt1;
  logic [3:0] gap;
  logic [1:0] grant;
  logic [1:0] done;
  logic       busy;
  logic       step_o;
  logic [2:0] model_state;
  logic       model_o;

  int checks;
  int errors;

  typedef struct {
    logic [1:0] req;
    logic [3:0] c0;
    logic [3:0] c1;
    logic [3:0] g;
    logic [1:0] eGrant;
    logic [1:0] eDone;
    logic       eBusy;
    logic       eStep;
    logic [2:0] eState;
    logic       eO;
  } vec_t;

  vec_t vecs[13];

  step_sched_ctrl #(.CNT_W(4), .GAP_W(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .cnt0        (cnt0),
    .cnt1        (cnt1),
    .gap         (gap),
    .grant       (grant),
    .done        (done),
    .busy        (busy),
    .step_o      (step_o),
    .model_state (model_state),
    .model_o     (model_o)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive inputs, let one rising edge pass, then settle away from the edge
  task automatic applyStimulus(input logic [1:0] r, input logic [3:0] c0,
                               input logic [3:0] c1, input logic [3:0] g);
    req  = r;
    cnt0 = c0;
    cnt1 = c1;
    gap  = g;
    @(posedge clk);
    #1;
  endtask

  task automatic checkValue(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic checkOutput(input string tag, input logic [1:0] eGrant,
                             input logic [1:0] eDone, input logic eBusy,
                             input logic eStep, input logic [2:0] eState,
                             input logic eO);
    checkValue({tag, " grant"}, int'(grant), int'(eGrant));
    checkValue({tag, " done"}, int'(done), int'(eDone));
    checkValue({tag, " busy"}, int'(busy), int'(eBusy));
    checkValue({tag, " step_o"}, int'(step_o), int'(eStep));
    checkValue({tag, " model_state"}, int'(model_state), int'(eState));
    checkValue({tag, " model_o"}, int'(model_o), int'(eO));
  endtask

  initial begin
    logic [1:0] tieGrant[9];
    logic [1:0] tieDone[9];
    logic [2:0] walkState[5];
    int         stepCount;

    checks = 0;
    errors = 0;

    // cnt0=3 gap=0, then cnt0=2 gap=2 with mid-service input changes, then cnt1=0
    vecs[0]  = '{2'b01, 4'd3, 4'd0, 4'd0, 2'b01, 2'b00, 1'b1, 1'b1, 3'b000, 1'b1};
    vecs[1]  = '{2'b00, 4'd3, 4'd0, 4'd0, 2'b01, 2'b00, 1'b1, 1'b1, 3'b001, 1'b0};
    vecs[2]  = '{2'b00, 4'd3, 4'd0, 4'd0, 2'b01, 2'b00, 1'b1, 1'b1, 3'b010, 1'b0};
    vecs[3]  = '{2'b00, 4'd3, 4'd0, 4'd0, 2'b01, 2'b01, 1'b1, 1'b0, 3'b011, 1'b1};
    vecs[4]  = '{2'b00, 4'd3, 4'd0, 4'd0, 2'b00, 2'b00, 1'b0, 1'b0, 3'b011, 1'b1};
    vecs[5]  = '{2'b01, 4'd2, 4'd0, 4'd2, 2'b01, 2'b00, 1'b1, 1'b1, 3'b011, 1'b1};
    vecs[6]  = '{2'b00, 4'd7, 4'd0, 4'd0, 2'b01, 2'b00, 1'b1, 1'b0, 3'b100, 1'b0};
    vecs[7]  = '{2'b00, 4'd7, 4'd0, 4'd0, 2'b01, 2'b00, 1'b1, 1'b0, 3'b100, 1'b0};
    vecs[8]  = '{2'b00, 4'd7, 4'd0, 4'd0, 2'b01, 2'b00, 1'b1, 1'b1, 3'b100, 1'b0};
    vecs[9]  = '{2'b00, 4'd7, 4'd0, 4'd0, 2'b01, 2'b01, 1'b1, 1'b0, 3'b001, 1'b0};
    vecs[10] = '{2'b10, 4'd7, 4'd0, 4'd0, 2'b00, 2'b00, 1'b0, 1'b0, 3'b001, 1'b0};
    vecs[11] = '{2'b10, 4'd7, 4'd0, 4'd0, 2'b10, 2'b10, 1'b1, 1'b0, 3'b001, 1'b0};
    vecs[12] = '{2'b00, 4'd7, 4'd0, 4'd0, 2'b00, 2'b00, 1'b0, 1'b0, 3'b001, 1'b0};

    // Reset held for two cycles
    rst = 1'b1;
    applyStimulus(2'b00, 4'd0, 4'd0, 4'd0);
    applyStimulus(2'b00, 4'd0, 4'd0, 4'd0);
    checkOutput("reset", 2'b00, 2'b00, 1'b0, 1'b0, 3'b000, 1'b1);
    rst = 1'b0;

    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i].req, vecs[i].c0, vecs[i].c1, vecs[i].g);
      checkOutput($sformatf("vec%0d", i), vecs[i].eGrant, vecs[i].eDone,
                  vecs[i].eBusy, vecs[i].eStep, vecs[i].eState, vecs[i].eO);
    end

    // Both requesting with counts of 1: grants alternate, IDLE gap between services
    tieGrant = '{2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00, 2'b01, 2'b01, 2'b00};
    tieDone  = '{2'b00, 2'b01, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b01, 2'b00};
    for (int i = 0; i < 9; i++) begin
      applyStimulus((i < 7) ? 2'b11 : 2'b00, 4'd1, 4'd1, 4'd0);
      checkValue($sformatf("tie%0d grant", i), int'(grant), int'(tieGrant[i]));
      checkValue($sformatf("tie%0d done", i), int'(done), int'(tieDone[i]));
    end
    checkValue("tie model_state", int'(model_state), 4);
    checkValue("tie model_o", int'(model_o), 0);

    // Reset asserted while a 4-pulse service with gap 3 sits in GAP
    applyStimulus(2'b01, 4'd4, 4'd0, 4'd3);
    applyStimulus(2'b00, 4'd4, 4'd0, 4'd3);
    applyStimulus(2'b00, 4'd4, 4'd0, 4'd3);
    checkValue("gap before abort step_o", int'(step_o), 0);
    rst = 1'b1;
    applyStimulus(2'b00, 4'd0, 4'd0, 4'd0);
    checkOutput("abort", 2'b00, 2'b00, 1'b0, 1'b0, 3'b000, 1'b1);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(2'b00, 4'd0, 4'd0, 4'd0);
      checkValue($sformatf("post-abort%0d done", i), int'(done), 0);
      checkValue($sformatf("post-abort%0d grant", i), int'(grant), 0);
    end

    // Five pulses from reset walk S1..S4 and wrap back to S1
    walkState = '{3'b001, 3'b010, 3'b011, 3'b100, 3'b001};
    stepCount = 0;
    applyStimulus(2'b01, 4'd5, 4'd0, 4'd0);
    if (step_o) stepCount++;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(2'b00, 4'd0, 4'd0, 4'd0);
      if (step_o) stepCount++;
      checkValue($sformatf("walk%0d model_state", i), int'(model_state), int'(walkState[i]));
    end
    checkValue("walk done", int'(done), 1);
    checkValue("walk model_o", int'(model_o), 0);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(2'b00, 4'd0, 4'd0, 4'd0);
      if (step_o) stepCount++;
    end
    checkValue("walk step count", stepCount, 5);
    checkValue("walk idle grant", int'(grant), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/step_sched_ctrl.md
# step_sched_ctrl

Two-requester scheduler that shares the 5-state step-counting FSM between two clients. It grants the FSM to one requester at a time in round-robin order and emits that requester's programmed number of single-cycle step pulses on the FSM's `i` input, with a programmable inter-pulse gap. It carries a cycle-exact shadow model of the FSM state and output so clients can read the expected result without probing the FSM. It sits directly in front of the FSM's `i` input.

## Interface
- `CNT_W`, default 4: width of per-requester step-count field.
- `GAP_W`, default 4: width of inter-pulse gap field.
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `req` input 2: per-requester service request, level.
- `cnt0`, `cnt1` input CNT_W: step count for requester 0/1, sampled at grant.
- `gap` input GAP_W: idle cycles between pulses, sampled at grant.
- `grant` output 2: one-hot owner; held for the whole service, including DONE.
- `done` output 2: one-cycle pulse to the owner at the end of service.
- `busy` output 1: high whenever `grant` is nonzero.
- `step_o` output 1: registered step pulse driving the FSM `i` input.
- `model_state` output 3: predicted FSM state, encoded S0=000 through S4=100.
- `model_o` output 1: predicted FSM output `O`.

## Operation
- Controller states: IDLE, PULSE, GAP, DONE.
- IDLE: if `req` is nonzero, arbitrate, set the `grant` bit, latch the count (`cnt0`/`cnt1`) into `remaining` and `gap` into `gap_reg`. Next state is PULSE if the count is nonzero, else DONE.
- Arbitration: when only one request is present, that requester wins. When both are present, the requester not served last wins. The last-served pointer resets to 1, so requester 0 wins the first tie.
- PULSE: `step_o`=1 for exactly one cycle; `remaining` decrements at the end of the cycle.
  - Next state: DONE if the decremented value is 0.
  - Otherwise PULSE again if `gap_reg`=0.
  - Otherwise GAP, loading the gap counter with `gap_reg`.
- GAP: `step_o`=0 for exactly `gap_reg` cycles, then PULSE.
- DONE: `done[owner]`=1 for one cycle, `grant` still held, last-served pointer updated. Next state is IDLE and `grant` clears.
- Deasserting `req` mid-service is ignored; the service runs to completion. `cnt*` and `gap` changes during service are ignored.
- Shadow model: updates on every edge where `step_o`=1.
  - S0→S1 sets O=0.
  - S1→S2 leaves O unchanged.
  - S2→S3 sets O=1.
  - S3→S4 sets O=0.
  - S4→S1 (wrap) leaves O unchanged.
  - The model state persists across services; it is not reset between grants.
- Count arithmetic is unsigned. `remaining` never underflows, because PULSE is entered only when it is nonzero.

## Timing
- Reset values: state IDLE, `grant`=00, `done`=00, `busy`=0, `step_o`=0, `model_state`=S0, `model_o`=1, pointer=1.
- `rst` has priority over all other inputs. If asserted mid-service, all outputs take their reset values at that edge, and no `done` is issued for the aborted service.
- Grant latency: `req` seen in cycle t gives `grant`/`busy` in t+1. The first `step_o` is also in t+1 if the count is nonzero; if the count is 0, `done` is in t+1.
- Service length for N>0 pulses with gap G: N + (N−1)·G + 1 cycles of `grant`.
- IDLE lasts at least one cycle between services, so there are no back-to-back grants.
- `model_state`/`model_o` reflect a step one cycle after the `step_o` pulse, which is the same edge the FSM samples `i`.

## Structure
- Package `step_sched_pkg`:
  - controller state enum (IDLE/PULSE/GAP/DONE);
  - FSM state constants S0–S4 (000–100);
  - reset value of `model_o`.
- Sub-module `step_fsm_model`: the shadow 5-state model. Inputs are `clk`, `rst` and `step`; outputs are `model_state` and `model_o`.

## Test plan
- Reset: hold `rst` 2 cycles → all outputs at reset values; `model_state`=000, `model_o`=1.
- `req`=01, `cnt0`=3, `gap`=0 at t0 → `step_o` high t1–t3, `done`=01 at t4, `grant` clears t5, `model_state`=011, `model_o`=1.
- `req`=11, both counts 1, held → grant order 01, 10, 01; `done` alternates; the second service starts 2 cycles after the first `done`.
- `cnt0`=2, `gap`=2 → `step_o` pulses at t1 and t4, `done` at t5; `cnt1`=0 → `grant`=10 and `done`=10 both at t+1, no `step_o`, model unchanged.
- `cnt0`=5 from reset → model walks S1..S4, then wraps to S1; final `model_state`=001, `model_o`=0.
- `rst` asserted during GAP of a 4-pulse service → next cycle `grant`=00, `step_o`=0, `model_state`=000, no `done` pulse.
